// File: rtl/demux_1to9_buf_if.sv
// demux_1to9_buf_if: producer-side and channel-side handshake bundle for demux_1to9_buf
interface demux_1to9_buf_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_sel;
    logic [WIDTH-1:0] in_data;
    logic [8:0]       out_valid;
    logic [8:0]       out_ready;
    logic [9*WIDTH-1:0] out_data;
    logic             sel_err;
    logic [CNT_W-1:0] drop_cnt;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data, sel_err, drop_cnt
    );
    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data, sel_err, drop_cnt
    );
endinterface

// File: rtl/demux_1to9_buf.sv
// demux_1to9_buf: routes a tagged word stream to 9 one-entry buffered channels; optional DEMUX_BROADCAST_EN makes sel 15 a broadcast
module demux_1to9_buf #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst,
    demux_1to9_buf_if.slave bus
);
    logic [8:0]         valid_q;
    logic [9*WIDTH-1:0] data_q;
    logic               err_q;
    logic [CNT_W-1:0]   drop_q;
    logic [15:0]        free;
    logic               sel_ok;
    logic               bcast;
    logic               accept;
    logic               drop;
    logic [8:0]         load;

    always_comb begin
        free   = {7'd0, ~valid_q | bus.out_ready};
        sel_ok = bus.in_sel < 4'd9;
`ifdef DEMUX_BROADCAST_EN
        bcast  = bus.in_sel == 4'd15;
`else
        bcast  = 1'b0;
`endif
        bus.in_ready = rst ? 1'b0 : bcast ? &free[8:0] : sel_ok ? free[bus.in_sel] : 1'b1;
        accept = bus.in_valid & bus.in_ready;
        drop   = accept & ~sel_ok & ~bcast;
        load   = !accept ? 9'd0 : bcast ? 9'h1FF : sel_ok ? 9'd1 << bus.in_sel : 9'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            for (int k = 0; k < 9; k++) begin
                if (load[k]) begin
                    valid_q[k]                <= 1'b1;
                    data_q[k*WIDTH +: WIDTH]  <= bus.in_data;
                end else if (bus.out_ready[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
            err_q <= drop;
            if (drop && drop_q != '1)
                drop_q <= drop_q + CNT_W'(1);
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.sel_err   = err_q;
    assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_demux_1to9_buf.sv
// tb_demux_1to9_buf: directed self-checking bench for demux_1to9_buf
module tb_demux_1to9_buf;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    demux_1to9_buf_if #(.WIDTH(1), .CNT_W(8)) bus ();
    demux_1to9_buf #(.WIDTH(1), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b1;
        bus.in_sel    = 4'd9;
        bus.in_data   = 1'b0;
        bus.out_ready = 9'h1FF;
        tick();
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_sel_err", 32'(bus.sel_err), 0);
        check("rst_drop_cnt", 32'(bus.drop_cnt), 0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        tick();

        bus.in_valid = 1'b1;
        bus.in_sel   = 4'd0;
        bus.in_data  = 1'b1;
        #1;
        check("first_in_ready", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        check("first_valid", 32'(bus.out_valid), 32'h001);
        check("first_data", 32'(bus.out_data[0]), 1);
        tick();
        check("first_drain", 32'(bus.out_valid), 0);

        for (int k = 0; k < 9; k++) begin
            bus.in_valid = 1'b1;
            bus.in_sel   = 4'(k);
            bus.in_data  = 1'b1;
            #1;
            check($sformatf("sweep_ready_%0d", k), 32'(bus.in_ready), 1);
            tick();
            check($sformatf("sweep_valid_%0d", k), 32'(bus.out_valid), 32'(1) << k);
            check($sformatf("sweep_data_%0d", k), 32'(bus.out_data[k]), 1);
        end
        bus.in_valid = 1'b0;
        tick();
        check("sweep_end", 32'(bus.out_valid), 0);

        bus.out_ready = 9'h1FB;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 4'd2;
        bus.in_data   = 1'b1;
        tick();
        check("stall_first", 32'(bus.out_valid), 32'h004);
        bus.in_data = 1'b0;
        #1;
        check("stall_ready", 32'(bus.in_ready), 0);
        tick();
        check("stall_hold_valid", 32'(bus.out_valid), 32'h004);
        check("stall_hold_data", 32'(bus.out_data[2]), 1);
        bus.in_sel = 4'd3;
        #1;
        check("other_ready", 32'(bus.in_ready), 1);
        tick();
        check("other_valid", 32'(bus.out_valid), 32'h00C);
        check("other_data", 32'(bus.out_data[3]), 0);
        bus.in_sel = 4'd2;
        #1;
        check("stall_still", 32'(bus.in_ready), 0);
        bus.out_ready = 9'h1FF;
        #1;
        check("stall_release", 32'(bus.in_ready), 1);
        tick();
        check("replace_valid", 32'(bus.out_valid), 32'h004);
        check("replace_data", 32'(bus.out_data[2]), 0);
        bus.in_valid = 1'b0;
        bus.in_sel   = 4'd1;
        tick();
        check("idle_ignored", 32'(bus.out_valid), 0);

        bus.in_valid = 1'b1;
        bus.in_sel   = 4'd9;
        #1;
        check("bad9_ready", 32'(bus.in_ready), 1);
        tick();
        check("bad9_err", 32'(bus.sel_err), 1);
        check("bad9_cnt", 32'(bus.drop_cnt), 1);
        check("bad9_valid", 32'(bus.out_valid), 0);
        bus.in_sel = 4'd15;
        tick();
`ifdef DEMUX_BROADCAST_EN
        check("sel15_err", 32'(bus.sel_err), 0);
        check("sel15_cnt", 32'(bus.drop_cnt), 1);
        check("sel15_valid", 32'(bus.out_valid), 32'h1FF);
`else
        check("bad15_err", 32'(bus.sel_err), 1);
        check("bad15_cnt", 32'(bus.drop_cnt), 2);
        check("bad15_valid", 32'(bus.out_valid), 0);
`endif
        bus.in_valid = 1'b0;
        tick();
        check("err_pulse_end", 32'(bus.sel_err), 0);

        bus.in_valid = 1'b1;
        bus.in_sel   = 4'd10;
        for (int i = 0; i < 300; i++) tick();
        check("drop_saturate", 32'(bus.drop_cnt), 255);
        bus.in_valid = 1'b0;
        tick();
        check("drop_hold", 32'(bus.drop_cnt), 255);

        bus.out_ready = 9'h1DF;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 4'd5;
        bus.in_data   = 1'b1;
        tick();
        check("ch5_full", 32'(bus.out_valid), 32'h020);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check("midrst_valid", 32'(bus.out_valid), 0);
        check("midrst_cnt", 32'(bus.drop_cnt), 0);
        check("midrst_data", 32'(bus.out_data), 0);
        bus.out_ready = 9'h1FF;
        tick();

`ifdef DEMUX_BROADCAST_EN
        bus.in_valid = 1'b1;
        bus.in_sel   = 4'd15;
        bus.in_data  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("bcast_valid", 32'(bus.out_valid), 32'h1FF);
        check("bcast_data", 32'(bus.out_data), 32'h1FF);
        check("bcast_cnt", 32'(bus.drop_cnt), 0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
